// File: rtl/keccak_pipe_stall.sv
// Multi-stage pipeline register for the Keccak state with downstream stall,
// bubble collapsing, synchronous flush, occupancy count and sticky drop flag.
module keccak_pipe_stall #(
  parameter int STAGES = 2,
  parameter int DW     = 1600,
  parameter int IXW    = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              pushin,
  input  logic [IXW-1:0]                    dix,
  input  logic [DW-1:0]                     din,
  input  logic                              stopin,
  output logic                              stopout,
  output logic                              pushout,
  output logic [IXW-1:0]                    doutix,
  output logic [DW-1:0]                     dout_p,
  output logic [$clog2(STAGES+1)-1:0]       count,
  output logic                              drop_err
);

  localparam int CW = $clog2(STAGES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STAGES);

  logic [STAGES-1:0] r_v;
  logic [IXW-1:0]    r_ix [STAGES];
  logic [DW-1:0]     r_d  [STAGES];
  logic [CW-1:0]     r_count;
  logic              r_drop;

  logic [STAGES-1:0] w_ready;
  logic              w_accept;
  logic              w_pop;

  // A stage can take a new word if it is empty or its successor is moving;
  // empty stages therefore keep advancing while the output is stalled.
  always_comb begin
    w_ready             = '0;
    w_ready[STAGES-1]   = !r_v[STAGES-1] || !stopin;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_ready[k] = !r_v[k] || w_ready[k+1];
    end
  end

  assign w_accept = pushin && w_ready[0] && !flush;
  assign w_pop    = r_v[STAGES-1] && !stopin;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value, giving a true shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_ready[0]) r_v[0] <= pushin;
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) r_v[k] <= r_v[k-1];
      end
    end
  end

  // NOTE: the wide data/index registers are reset on purpose so the
  // outputs read zero after reset; otherwise they load only real words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ix[k] <= '0;
        r_d[k]  <= '0;
      end
    end else begin
      if (w_accept) begin
        r_ix[0] <= dix;
        r_d[0]  <= din;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (!flush && w_ready[k] && r_v[k-1]) begin
          r_ix[k] <= r_ix[k-1];
          r_d[k]  <= r_d[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      unique case ({w_accept, w_pop})
        2'b10:   if (r_count != C_MAX) r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0)    r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A word offered while stalled is lost; remember it until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= 1'b0;
    end else if (pushin && !w_ready[0] && !flush) begin
      r_drop <= 1'b1;
    end
  end

  assign stopout  = !w_ready[0];
  assign pushout  = r_v[STAGES-1];
  assign doutix   = r_ix[STAGES-1];
  assign dout_p   = r_d[STAGES-1];
  assign count    = r_count;
  assign drop_err = r_drop;

endmodule

// File: doc/keccak_pipe_stall.md
Name: keccak_pipe_stall

Overview:
- Parametrised, multi-stage pipeline register for the SHA3 permutation datapath.
- Carries a 5x5x64 state (or any DW-bit word) plus a transaction index through STAGES register stages.
- Adds downstream backpressure (stopin/stopout), bubble collapsing, synchronous flush, occupancy count and a sticky drop-error flag.
- Sits between Keccak round stages wherever the consumer can stall.

Parameters:
- STAGES, 2, number of register stages, at least 1; latency with no stall.
- DW, 1600, data width (5*5*64 state, flattened LSB = lane [0][0] bit 0).
- IXW, 24, index/tag width.

Ports:
- clk  input  1  clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted at 0, deasserts synchronously to clk.
- flush  input  1  synchronous clear of all stage valids.
- pushin  input  1  input word valid.
- dix  input  IXW  input index.
- din  input  DW  input state.
- stopin  input  1  downstream stall; last stage must hold while 1.
- stopout  output  1  upstream stall; combinational from valids and stopin.
- pushout  output  1  last-stage valid.
- doutix  output  IXW  last-stage index.
- dout_p  output  DW  last-stage state.
- count  output  $clog2(STAGES+1)  occupied stages.
- drop_err  output  1  sticky: a push was presented while stopout=1.

Behaviour:
- Reset (reset=0, asynchronous): all stage valids=0, all index/data regs=0, count=0, drop_err=0. Therefore pushout=0, doutix=0, dout_p=0, stopout=0.
- Per stage k (0 = input side, S-1 = output side):
  - ready[S-1] = !v[S-1] | !stopin.
  - ready[k] = !v[k] | ready[k+1].
  - stopout = !ready[0].
- Stage k>0 loads from k-1 when ready[k]:
  - v[k] <= v[k-1].
  - Data/index are copied only when v[k-1]=1; otherwise they hold, and no bubble data is copied.
- Stage 0 loads when ready[0]: v[0] <= pushin & !flush; data/index captured only on accept.
- accept = pushin & ready[0] & !flush.
- Stage whose ready is 0: holds v, index and data unchanged.
- Bubble collapsing: while downstream is stalled, empty stages still advance. Up to STAGES words are stored before stopout asserts.
- Latency: a word accepted at edge N appears with pushout=1 after edge N+STAGES-1, i.e. STAGES cycles with no stall. Full throughput is one word per cycle.
- Output consumed on a cycle where pushout=1 and stopin=0.
- dout_p/doutix hold last-stage contents when pushout=0. They are not forced to zero except by reset.
- count <= count + accept - (pushout & !stopin), saturating within 0..STAGES. count equals the sum of v[].
- drop_err:
  - Set on pushin & stopout & !flush; cleared only by reset.
  - The offending word is discarded; pipeline state is unaffected.
- flush=1 at an edge:
  - All v <= 0 and count <= 0; the same-cycle pushin is discarded without setting drop_err.
  - Data regs hold.
  - pushout may be 1 during the flush cycle; the downstream consumption in that cycle is still valid.
- stopin toggling while pushout=0 has no effect on the pipeline except the ready chain.
- Reset mid-operation: all in-flight words are lost immediately (asynchronous). The first accept after release behaves as from empty.
- STAGES=1: single register with stall. stopout = v[0] & stopin.

Test Plan:
- Reset/idle: hold reset=0 with random inputs, release -> pushout=0, doutix=0, dout_p=0, count=0, drop_err=0, stopout=0.
- Streaming, STAGES=3, stopin=0: push dix=1..5 on consecutive cycles -> pushout high for 5 cycles starting 3 cycles after the first push; doutix=1,2,3,4,5 in order with matching din; count peaks at 3.
- Stall/collapse, STAGES=3:
  - Push dix=7 into an empty pipe with stopin=1 -> reaches the last stage after 3 cycles and holds.
  - Push 8 and 9 -> count=3 and stopout=1.
  - Release stopin -> 7, 8, 9 out on consecutive cycles, nothing lost or duplicated.
- Drop: with the pipe full and stopout=1, push dix=0xABCDEF -> word never appears at output; drop_err=1 and stays 1 through later traffic until reset.
- Flush: pipe holds 3 words, assert flush together with pushin (dix=0x10) -> next cycle count=0 and pushout=0, 0x10 never emerges, drop_err unchanged.
- Async reset mid-stream: assert reset=0 between clock edges with count=2 -> outputs zero immediately. After release, push dix=0x55 -> emerges alone after STAGES cycles.
